// File: rtl/encrypt_pkg.sv
// Shared definitions for the word-stream encryption engine: FSM encoding,
// ALU op encoding and the mode/index to op lookup.
package encrypt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_AND = 2'd1,
        OP_SUB = 2'd2,
        OP_XOR = 2'd3
    } op_t;

    // Decrypt swaps add and sub so that indices 0 and 2 undo each other;
    // AND and XOR keep the same slot in both tables.
    function automatic op_t op_lookup(input logic mode, input logic [1:0] idx);
        op_t op;
        case (idx)
            2'd0:    op = mode ? OP_SUB : OP_ADD;
            2'd1:    op = OP_AND;
            2'd2:    op = mode ? OP_ADD : OP_SUB;
            2'd3:    op = OP_XOR;
            default: op = OP_XOR;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/encrypt_alu.sv
// Combinational DW-wide key operation unit; all arithmetic wraps modulo 2^DW.
module encrypt_alu
    import encrypt_pkg::*;
#(
    parameter int DW = 32
)(
    input  logic          i_mode,
    input  logic [1:0]    i_idx,
    input  logic [DW-1:0] i_data,
    input  logic [DW-1:0] i_key,
    output logic [DW-1:0] o_result
);

    op_t w_op;

    assign w_op = op_lookup(i_mode, i_idx);

    // Selected data/key operation.
    always_comb begin
        o_result = {DW{1'b0}};
        case (w_op)
            OP_ADD:  o_result = i_data + i_key;
            OP_AND:  o_result = i_data & i_key;
            OP_SUB:  o_result = i_data - i_key;
            OP_XOR:  o_result = i_data ^ i_key;
            default: o_result = {DW{1'b0}};
        endcase
    end

endmodule

// File: rtl/encrypt_stream.sv
// Word-stream encryption engine: reads data and key RAMs, applies a per-word
// key operation and writes results through a PIPE-deep result pipeline.
module encrypt_stream
    import encrypt_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 9,
    parameter int KAW  = 8,
    parameter int PIPE = 3
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic           mode,
    input  logic [AW-1:0]  length,
    input  logic [AW-1:0]  src_base,
    input  logic [AW-1:0]  dst_base,
    input  logic [KAW-1:0] key_base,
    input  logic [KAW-1:0] key_len,
    output logic [AW-1:0]  rd_addr,
    output logic [KAW-1:0] key_addr,
    input  logic [DW-1:0]  data_in,
    input  logic [DW-1:0]  key_in,
    output logic           we,
    output logic [AW-1:0]  wr_addr,
    output logic [DW-1:0]  wr_data,
    output logic           busy,
    output logic           done,
    output logic           err
);

    state_t r_state;
    state_t w_state_nxt;

    logic w_accept;
    logic w_issue;
    logic w_flush;
    logic w_last;
    logic w_inflight;

    logic           r_mode;
    logic [AW-1:0]  r_len;
    logic [AW-1:0]  r_idx;
    logic [AW-1:0]  r_rd_addr;
    logic [AW-1:0]  r_dst_addr;
    logic [KAW-1:0] r_key_base;
    logic [KAW-1:0] r_klen;
    logic [KAW-1:0] r_kidx;
    logic [KAW-1:0] r_key_addr;
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    logic           r_s0_vld;
    logic [1:0]     r_s0_idx;
    logic [AW-1:0]  r_s0_addr;

    logic [DW-1:0]  w_alu_res;
    logic           r_alu_vld;
    logic [AW-1:0]  r_alu_addr;
    logic [DW-1:0]  r_alu_data;

    logic [PIPE:0]         w_vld;
    logic [PIPE:0]         w_up;
    logic [PIPE:0][AW-1:0] w_addr;
    logic [PIPE:0][DW-1:0] w_data;

    assign w_last = (r_idx == (r_len - AW'(1)));

    // Valids that will still be in flight after this edge (everything but the write stage).
    always_comb begin
        w_up       = w_vld;
        w_up[PIPE] = 1'b0;
    end

    assign w_inflight = r_s0_vld | (|w_up);

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_accept = 1'b1;
                    if (key_len == {KAW{1'b0}}) begin
                        w_state_nxt = ST_DONE;
                    end else if (length == {AW{1'b0}}) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_issue = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (!w_inflight) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job parameters, address counters and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode     <= 1'b0;
            r_len      <= {AW{1'b0}};
            r_idx      <= {AW{1'b0}};
            r_rd_addr  <= {AW{1'b0}};
            r_dst_addr <= {AW{1'b0}};
            r_key_base <= {KAW{1'b0}};
            r_klen     <= {KAW{1'b0}};
            r_kidx     <= {KAW{1'b0}};
            r_key_addr <= {KAW{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_mode     <= mode;
                r_len      <= length;
                r_idx      <= {AW{1'b0}};
                r_rd_addr  <= src_base;
                r_dst_addr <= dst_base;
                r_key_base <= key_base;
                r_klen     <= key_len;
                r_kidx     <= {KAW{1'b0}};
                r_key_addr <= key_base;
                r_busy     <= 1'b1;
                r_err      <= (key_len == {KAW{1'b0}});
            end else if (w_issue) begin
                r_idx      <= r_idx + AW'(1);
                r_rd_addr  <= r_rd_addr + AW'(1);
                r_dst_addr <= r_dst_addr + AW'(1);
                if (r_kidx == (r_klen - KAW'(1))) begin
                    r_kidx     <= {KAW{1'b0}};
                    r_key_addr <= r_key_base;
                end else begin
                    r_kidx     <= r_kidx + KAW'(1);
                    r_key_addr <= r_key_addr + KAW'(1);
                end
            end else begin
                if (w_flush) begin
                    r_err <= 1'b1;
                end
                if (r_state == ST_DONE) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    // Issue stage: tags the word whose RAM data arrives next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s0_vld  <= 1'b0;
            r_s0_idx  <= 2'd0;
            r_s0_addr <= {AW{1'b0}};
        end else begin
            r_s0_vld  <= w_issue;
            r_s0_idx  <= r_idx[1:0];
            r_s0_addr <= r_dst_addr;
        end
    end

    encrypt_alu #(
        .DW (DW)
    ) u_alu (
        .i_mode   (r_mode),
        .i_idx    (r_s0_idx),
        .i_data   (data_in),
        .i_key    (key_in),
        .o_result (w_alu_res)
    );

    // ALU result stage; stage 0 of the result pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_vld  <= 1'b0;
            r_alu_addr <= {AW{1'b0}};
            r_alu_data <= {DW{1'b0}};
        end else begin
            r_alu_vld  <= w_flush ? 1'b0 : r_s0_vld;
            r_alu_addr <= r_s0_addr;
            r_alu_data <= w_alu_res;
        end
    end

    assign w_vld[0]  = r_alu_vld;
    assign w_addr[0] = r_alu_addr;
    assign w_data[0] = r_alu_data;

    for (genvar k = 1; k <= PIPE; k++) begin : g_pipe
        logic          r_vld;
        logic [AW-1:0] r_addr;
        logic [DW-1:0] r_data;

        // One extra result register stage, flushed on abort.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_vld  <= 1'b0;
                r_addr <= {AW{1'b0}};
                r_data <= {DW{1'b0}};
            end else begin
                r_vld  <= w_flush ? 1'b0 : w_vld[k-1];
                r_addr <= w_addr[k-1];
                r_data <= w_data[k-1];
            end
        end

        assign w_vld[k]  = r_vld;
        assign w_addr[k] = r_addr;
        assign w_data[k] = r_data;
    end

    assign rd_addr  = r_rd_addr;
    assign key_addr = r_key_addr;
    assign we       = w_vld[PIPE];
    assign wr_addr  = w_addr[PIPE];
    assign wr_data  = w_data[PIPE];
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: doc/encrypt_stream.md
Name: encrypt_stream

Overview:
- Parametrised next-generation word-stream encryption engine for the 3DES datapath.
- Reads a block of data words and key words from synchronous RAMs and applies a per-word key operation selected by word index and mode.
- Writes results to a separate destination region through a configurable-depth pipeline.
- Adds runtime length, base addresses, key length, decrypt mode, abort and error status; sits between the memory controller and the top-level sequencer.

Parameters:
- DW, 32, data/key word width.
- AW, 9, data RAM address width.
- KAW, 8, key RAM address width.
- PIPE, 3, extra result register stages after the ALU stage (0..8).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- abort  in  1  synchronous abort of a running job.
- mode  in  1  0 = encrypt table, 1 = decrypt table.
- length  in  AW  number of words to process.
- src_base  in  AW  first source word address.
- dst_base  in  AW  first destination word address.
- key_base  in  KAW  first key word address.
- key_len  in  KAW  key words before key index wraps.
- rd_addr  out  AW  data RAM read address.
- key_addr  out  KAW  key RAM read address.
- data_in  in  DW  read data, valid 1 cycle after rd_addr.
- key_in  in  DW  key data, valid 1 cycle after key_addr.
- we  out  1  write enable.
- wr_addr  out  AW  write address.
- wr_data  out  DW  write data.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  status of the last job, held until the next start.

Behaviour:
- Reset (reset low, any time including mid-job): FSM to IDLE, all pipeline valids cleared. Outputs: busy, done, err, we = 0; rd_addr, key_addr, wr_addr, wr_data = 0. No write occurs after reset assertion.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on start=1 and abort=0, latch mode, length, all bases and key_len; clear err; busy=1.
  - If key_len==0: go to DONE with err=1; no reads, no writes.
  - Else if length==0: go to DONE with err=0.
  - Else go to RUN.
  - abort in IDLE is ignored.
- RUN: one word issued per cycle for index i = 0..length-1.
  - rd_addr = src_base+i, mod 2^AW.
  - key_addr = key_base+k, mod 2^KAW, where k counts 0..key_len-1 and then wraps to 0.
  - After issuing i = length-1, go to DRAIN.
- DRAIN: wait until all pipeline valid bits are 0, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 on the following cycle, return to IDLE. start held high re-launches only from IDLE, so at least one idle cycle separates jobs.
- Latency: word issued in cycle n is written (we=1, wr_addr=dst_base+i mod 2^AW) in cycle n+2+PIPE. Throughput is 1 word/cycle.
- ALU stage (registered at cycle n+1 edge, operands data_in/key_in). Op = i[1:0]:
  - mode 0: 00 add, 01 and, 10 data-key, 11 xor.
  - mode 1: 00 data-key, 01 and, 10 add, 11 xor.
  - All arithmetic is modulo 2^DW; carries and borrows are discarded. Op 01 is not invertible, by definition.
- Pipeline: each stage carries a valid bit, wr_addr and data. we = valid of the last stage.
- Abort during RUN or DRAIN:
  - Issue stops.
  - All pipeline valids are cleared on the same edge, so no write occurs from the next cycle on.
  - FSM goes to DONE with err=1.
- Abort and the final issue in the same cycle: abort wins.
- Writes may overlap the source region. Each word's read always precedes its own write, so only later-index overlap is undefined, and that is the user's responsibility.

Decomposition:
- Package encrypt_pkg: FSM state encoding; op encodings (OP_ADD, OP_AND, OP_SUB, OP_XOR); the per-mode op lookup function.
- Sub-module encrypt_alu: combinational DW-wide op unit taking mode, idx[1:0], data and key.
- Top holds the FSM, counters and the PIPE-deep valid/addr/data shift register (generate loop; PIPE=0 supported).

Test Plan:
- mode 0, length=4, src_base=0, dst_base=0x100, key_base=0, key_len=4, data={10,0xFF,20,0xAA}, key={5,0x0F,3,0xFF}: writes 0x100..0x103 = {15,0x0F,17,0x55}; first we exactly 5 cycles after first rd_addr (PIPE=3); done 1 cycle after last we; err=0.
- mode 1 on the same data: writes {5,0x0F,23,0x55}; data 0, key 1, op sub gives 0xFFFFFFFF (wrap).
- length=6, key_len=2, key_base=0x10: key_addr sequence 0x10,0x11,0x10,0x11,0x10,0x11; src_base=0x1FE wraps rd_addr to 0x1FE,0x1FF,0x000,...
- key_len=0 -> done pulse 1 cycle after start, err=1, zero writes; length=0 with key_len=1 -> done, err=0, zero writes.
- length=20, abort raised in the 8th RUN cycle: no we from the following cycle on, done next cycle, err=1, busy low after; a new start then runs normally.
- reset driven low mid-DRAIN: we drops immediately, all outputs 0; after release, start runs a fresh 4-word job correctly.
